rom_loader: RTL and testbench

- Runtime instruction-memory writer for open_risc_v_soc: takes a byte stream over a valid/ready handshake, packs it little-endian into 32-bit words and writes them into the instruction ROM's write port from address 0 upward.
- Holds the core in reset while loading and releases it when the image is complete.
- Lets silicon and system benches load programs such as rv32ui test images without file preloading.

---
 rtl/rom_loader.sv | 115 +++++++++++
 tb/tb_rom_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// rom_loader: runtime instruction-memory writer.
//   It takes a byte stream over a valid/ready handshake and packs the bytes
//   little-endian into 32-bit words. It writes the words into the instruction
//   ROM write port, starting at address 0. The core is held in reset while the
//   load runs and is released once the image is complete.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start, load_len one-cycle load request and its word count (0..2^ADDR_W)
//   in_valid/in_ready/in_byte   byte stream handshake
//   rom_we/rom_waddr/rom_wdata  ROM write port, one write per word
//   core_rst_n      active-low reset to the core (high only when done)
//   busy, done      load in progress / image loaded
//   checksum        modulo-2^32 sum of words written in the current load
`timescale 1ns/1ps
module rom_loader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [DATA_W-1:0] rom_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_cnt;
  logic [1:0]        r_bidx;
  logic [23:0]       r_asm;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cs;
  logic [ADDR_W:0]   w_cnt_next;

  // The counter is one bit wider than the address so a full-depth load
  // (2^ADDR_W words) terminates without the address ever wrapping.
  assign w_cnt_next = r_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_bidx  <= '0;
      r_asm   <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_cs    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_cnt  <= '0;
            r_bidx <= '0;
            r_cs   <= '0;
            if (load_len != '0) begin
              r_len   <= load_len;
              r_state <= S_RECV;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_RECV: begin
          if (in_valid) begin
            r_bidx <= r_bidx + 1'b1;
            case (r_bidx)
              2'd0: r_asm[7:0]   <= in_byte;
              2'd1: r_asm[15:8]  <= in_byte;
              2'd2: r_asm[23:16] <= in_byte;
              default: begin
                // The fourth byte goes straight into the write-data register,
                // so the word is presented during the WRITE cycle itself.
                r_wdata <= {in_byte, r_asm};
                r_waddr <= r_cnt[ADDR_W-1:0];
                r_state <= S_WRITE;
              end
            endcase
          end
        end
        S_WRITE: begin
          r_cs    <= r_cs + r_wdata;
          r_cnt   <= w_cnt_next;
          r_state <= (w_cnt_next == r_len) ? S_DONE : S_RECV;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == S_RECV);
  assign rom_we     = (r_state == S_WRITE);
  assign busy       = (r_state == S_RECV) || (r_state == S_WRITE);
  assign done       = (r_state == S_DONE);
  assign core_rst_n = (r_state == S_DONE);
  assign rom_waddr  = r_waddr;
  assign rom_wdata  = r_wdata;
  assign checksum   = r_cs;

endmodule

// File: tb/tb_rom_loader.sv
`timescale 1ns/1ps
module tb_rom_loader;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   load_len = '0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_byte = '0;
  logic          in_ready;
  logic          rom_we;
  logic [AW-1:0] rom_waddr;
  logic [31:0]   rom_wdata;
  logic          core_rst_n;
  logic          busy;
  logic          done;
  logic [31:0]   checksum;

  rom_loader #(.ADDR_W(AW), .DATA_W(32)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .load_len   (load_len),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .rom_we     (rom_we),
    .rom_waddr  (rom_waddr),
    .rom_wdata  (rom_wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: the image as a byte queue, expected writes as a queue.
  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  logic [7:0]  img[$];
  wr_t         exp_q[$];
  wr_t         e;
  logic [31:0] exp_cs = '0;
  int          n_writes = 0;
  bit          final_pending = 1'b0;

  task automatic build_model(input int len);
    logic [31:0] w;
    exp_q.delete();
    exp_cs = '0;
    for (int i = 0; i < len; i++) begin
      w = 32'(img[4*i]) + 32'(img[4*i+1]) * 256 + 32'(img[4*i+2]) * 65536
        + 32'(img[4*i+3]) * 16777216;
      exp_q.push_back('{addr: i, data: w});
      exp_cs += w;
    end
  endtask

  task automatic rand_img(input int nbytes);
    img.delete();
    for (int i = 0; i < nbytes; i++) img.push_back(8'($urandom));
  endtask

  // Write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (final_pending) begin
      final_pending = 1'b0;
      chk("done_after_last", 32'(done), 32'd1);
      chk("core_run_after_last", 32'(core_rst_n), 32'd1);
    end
    if (rom_we) begin
      n_writes++;
      chk("ready_in_write", 32'(in_ready), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_we", 32'(rom_we), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("we_addr", 32'(rom_waddr), 32'(e.addr));
        chk("we_data", rom_wdata, e.data);
        if (exp_q.size() == 0) final_pending = 1'b1;
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_rom_we"}, 32'(rom_we), 32'd0);
    chk({tag, "_rom_waddr"}, 32'(rom_waddr), 32'd0);
    chk({tag, "_rom_wdata"}, rom_wdata, 32'd0);
    chk({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_checksum"}, checksum, 32'd0);
  endtask

  // mode: 0 = valid always high, 1 = valid toggles each cycle, 2 = random.
  // pulse_after > 0: pulse start (with a different load_len) after that many writes.
  task automatic do_load(input int len, input int mode, input int pulse_after);
    int idx;
    int cyc;
    int base;
    bit pulsed;
    bit v;
    bit acc;
    idx = 0;
    cyc = 0;
    pulsed = 1'b0;
    build_model(len);
    base = n_writes;
    @(negedge clk);
    start = 1'b1;
    load_len = (AW+1)'(len);
    @(negedge clk);
    start = 1'b0;
    if (len == 0) begin
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_core_run", 32'(core_rst_n), 32'd1);
      chk("zero_busy", 32'(busy), 32'd0);
      chk("zero_no_we", 32'(n_writes - base), 32'd0);
      return;
    end
    chk("load_done_low", 32'(done), 32'd0);
    chk("load_core_held", 32'(core_rst_n), 32'd0);
    chk("load_busy", 32'(busy), 32'd1);
    while (idx < 4*len && cyc < 20*len + 20) begin
      start = 1'b0;
      if (pulse_after > 0 && !pulsed && (n_writes - base) == pulse_after) begin
        start = 1'b1;
        load_len = 1;
        pulsed = 1'b1;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 0;
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_byte  = v ? img[idx] : 8'($urandom);
      acc = v && in_ready;
      @(negedge clk);
      if (acc) idx++;
      cyc++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    chk("bytes_consumed", 32'(idx), 32'(4*len));
    @(negedge clk);
    chk("end_done", 32'(done), 32'd1);
    chk("end_core_run", 32'(core_rst_n), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_in_ready", 32'(in_ready), 32'd0);
    chk("end_checksum", checksum, exp_cs);
    chk("write_count", 32'(n_writes - base), 32'(len));
    chk("writes_pending", 32'(exp_q.size()), 32'd0);
    // Bytes offered after completion must not be consumed.
    in_valid = 1'b1;
    in_byte  = 8'hA5;
    @(negedge clk);
    chk("done_in_ready", 32'(in_ready), 32'd0);
    chk("done_no_we", 32'(n_writes - base), 32'(len));
    in_valid = 1'b0;
  endtask

  initial begin
    #30;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_core_held", 32'(core_rst_n), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd0);

    // Basic load, then the same image under back-pressure.
    img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    do_load(2, 0, 0);
    chk("basic_checksum", checksum, 32'h001000A6);
    do_load(2, 1, 0);
    chk("bp_checksum", checksum, 32'h001000A6);

    // Zero length, then a one-word restart.
    img.delete();
    do_load(0, 0, 0);
    img = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_load(1, 0, 0);
    chk("deadbeef_data", rom_wdata, 32'hDEADBEEF);

    // Start pulsed mid-load is ignored.
    rand_img(12);
    do_load(3, 2, 1);

    // Reset mid-load after two bytes.
    rand_img(12);
    exp_q.delete();
    @(negedge clk);
    start = 1'b1;
    load_len = 3;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_byte = img[0];
    @(negedge clk);
    in_byte = img[1];
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk_reset_outputs("abort");
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_idle_busy", 32'(busy), 32'd0);
    chk("abort_idle_ready", 32'(in_ready), 32'd0);
    chk("abort_idle_core", 32'(core_rst_n), 32'd0);
    in_valid = 1'b0;

    // Full depth: 16 words on a 16-word ROM.
    rand_img(64);
    do_load(16, 2, 0);
    chk("full_last_addr", 32'(rom_waddr), 32'd15);

    // Random loads.
    for (int t = 0; t < 6; t++) begin
      int len;
      len = int'($urandom_range(1, 5));
      rand_img(4*len);
      do_load(len, 2, 0);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
